// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: special symbol codes, scrambler polynomial and
// the 8-step Galois LFSR advance used by the byte-wide scrambler.
package pcie_phy_pkg;

    localparam logic [7:0]  K_COM         = 8'hBC;
    localparam logic [7:0]  K_SKP         = 8'h1C;
    localparam logic [15:0] SCRAMBLE_POLY = 16'h0039;

    typedef enum logic [1:0] {
        SYM_DATA    = 2'd0,
        SYM_COM     = 2'd1,
        SYM_SKP     = 2'd2,
        SYM_K_OTHER = 2'd3
    } sym_class_t;

    typedef struct packed {
        logic [15:0] next_state;
        logic [7:0]  mask;
    } lfsr_step_t;

    // Eight Galois shifts; each pre-shift LFSR[15] becomes the next mask bit, bit 0 first.
    function automatic lfsr_step_t lfsr_adv8(input logic [15:0] state);
        lfsr_step_t  res;
        logic [15:0] s;
        s        = state;
        res.mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            res.mask[i] = s[15];
            s = {s[14:0], 1'b0} ^ (s[15] ? SCRAMBLE_POLY : 16'h0000);
        end
        res.next_state = s;
        return res;
    endfunction

endpackage

// File: rtl/pcie_scrambler_8b.sv
// Byte-wide PCIe Gen1/2 scrambler with a registered valid/ready output stage,
// sitting directly upstream of the 8b/10b encoder.
module pcie_scrambler_8b
    import pcie_phy_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] sym_i,
    input  logic       sym_k_i,
    input  logic       sym_valid_i,
    output logic       sym_ready_o,
    input  logic       scramble_dis_i,
    output logic [7:0] sym_o,
    output logic       sym_k_o,
    output logic       sym_valid_o,
    input  logic       sym_ready_i
);

    logic [15:0] lfsr_r;
    logic [7:0]  sym_r;
    logic        sym_k_r;
    logic        valid_r;

    logic        accept_s;
    sym_class_t  sym_class_s;
    lfsr_step_t  step_s;
    logic [15:0] lfsr_next_s;
    logic [7:0]  sym_next_s;

    // Ready depends only on the registered output stage, never on sym_valid_i.
    assign sym_ready_o = !valid_r || sym_ready_i;
    assign accept_s    = sym_valid_i && sym_ready_o;

    assign sym_o       = sym_r;
    assign sym_k_o     = sym_k_r;
    assign sym_valid_o = valid_r;

    // Classify the incoming symbol.
    always_comb begin
        sym_class_s = SYM_DATA;
        if (!sym_k_i) begin
            sym_class_s = SYM_DATA;
        end else if (sym_i == K_COM) begin
            sym_class_s = SYM_COM;
        end else if (sym_i == K_SKP) begin
            sym_class_s = SYM_SKP;
        end else begin
            sym_class_s = SYM_K_OTHER;
        end
    end

    // Next LFSR state and outgoing byte; scramble_dis_i only zeroes the mask.
    always_comb begin
        step_s      = lfsr_adv8(lfsr_r);
        lfsr_next_s = lfsr_r;
        sym_next_s  = sym_i;
        case (sym_class_s)
            SYM_COM: begin
                lfsr_next_s = LFSR_SEED;
                sym_next_s  = sym_i;
            end
            SYM_SKP: begin
                lfsr_next_s = lfsr_r;
                sym_next_s  = sym_i;
            end
            SYM_K_OTHER: begin
                lfsr_next_s = step_s.next_state;
                sym_next_s  = sym_i;
            end
            SYM_DATA: begin
                lfsr_next_s = step_s.next_state;
                sym_next_s  = scramble_dis_i ? sym_i : (sym_i ^ step_s.mask);
            end
            default: begin
                lfsr_next_s = lfsr_r;
                sym_next_s  = sym_i;
            end
        endcase
    end

    // LFSR and output stage; the LFSR moves only on an accepted symbol.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_r  <= LFSR_SEED;
            sym_r   <= 8'h00;
            sym_k_r <= 1'b0;
            valid_r <= 1'b0;
        end else if (accept_s) begin
            lfsr_r  <= lfsr_next_s;
            sym_r   <= sym_next_s;
            sym_k_r <= sym_k_i;
            valid_r <= 1'b1;
        end else if (sym_ready_i) begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pcie_scrambler_8b.sv
// Self-checking bench for pcie_scrambler_8b: directed sequences plus a
// randomized valid/ready stress run against a keystream-position model.
module tb_pcie_scrambler_8b;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sym_i;
    logic       sym_k_i;
    logic       sym_valid_i;
    logic       sym_ready_o;
    logic       scramble_dis_i;
    logic [7:0] sym_o;
    logic       sym_k_o;
    logic       sym_valid_o;
    logic       sym_ready_i;

    int checks   = 0;
    int failures = 0;

    // Precomputed scrambler keystream from the seed; the model tracks a bit position into it.
    localparam int KS_LEN = 90000;
    bit ks[KS_LEN];
    int ks_pos;

    logic       pre_acc;
    logic       pre_fire;
    logic [7:0] pre_sym;
    logic       pre_k;
    logic [8:0] exp_q[$];

    pcie_scrambler_8b dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sym_i         (sym_i),
        .sym_k_i       (sym_k_i),
        .sym_valid_i   (sym_valid_i),
        .sym_ready_o   (sym_ready_o),
        .scramble_dis_i(scramble_dis_i),
        .sym_o         (sym_o),
        .sym_k_o       (sym_k_o),
        .sym_valid_o   (sym_valid_o),
        .sym_ready_i   (sym_ready_i)
    );

    always #5 clk = ~clk;

    task automatic build_keystream();
        int unsigned st;
        st = 32'hFFFF;
        for (int i = 0; i < KS_LEN; i++) begin
            ks[i] = st[15];
            st = (st * 2) % 65536;
            if (ks[i]) st = st ^ 32'h0039;
        end
    endtask

    task automatic model_sym(input logic [7:0] s, input logic k, input logic dis,
                             output logic [8:0] res);
        logic [7:0] m;
        m = 8'h00;
        if (k && s == 8'hBC) begin
            ks_pos = 0;
            res = {1'b1, s};
        end else if (k && s == 8'h1C) begin
            res = {1'b1, s};
        end else begin
            for (int b = 0; b < 8; b++) m[b] = ks[ks_pos + b];
            ks_pos = ks_pos + 8;
            res = k ? {1'b1, s} : {1'b0, (dis ? s : (s ^ m))};
        end
    endtask

    task automatic step(input logic v, input logic [7:0] s, input logic k,
                        input logic d, input logic r);
        sym_valid_i = v; sym_i = s; sym_k_i = k; scramble_dis_i = d; sym_ready_i = r;
        @(negedge clk);
        pre_acc  = v && sym_ready_o;
        pre_fire = sym_valid_o && r;
        pre_sym  = sym_o;
        pre_k    = sym_k_o;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sym_valid_i = 1'b0; sym_i = 8'h00; sym_k_i = 1'b0;
        scramble_dis_i = 1'b0; sym_ready_i = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        ks_pos = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (sym_valid_o !== 1'b0 || sym_o !== 8'h00 || sym_k_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b sym=%h k=%b want 0/00/0",
                     sym_valid_o, sym_o, sym_k_o);
        end
        do_reset();
        checks++;
        if (sym_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", sym_ready_o);
        end
    endtask

    task automatic test_sequence(input string name, input logic [8:0] ins[5],
                                 input logic dis[5], input logic [8:0] exp[5]);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ins[i][7:0], ins[i][8], dis[i], 1'b1);
            checks++;
            if (sym_valid_o !== 1'b1 || {sym_k_o, sym_o} !== exp[i]) begin
                failures++;
                $display("FAIL %s[%0d]: got valid=%b k/sym=%h want 1/%h",
                         name, i, sym_valid_o, {sym_k_o, sym_o}, exp[i]);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (sym_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: got valid=%b want 0", name, sym_valid_o);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_after[2] = '{8'h17, 8'hC0};
        do_reset();
        step(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
            checks++;
            if (pre_acc !== 1'b0 || sym_valid_o !== 1'b1 || sym_o !== 8'hFF ||
                sym_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got acc=%b valid=%b sym=%h rdy=%b want 0/1/ff/0",
                         i, pre_acc, sym_valid_o, sym_o, sym_ready_o);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
            checks++;
            if (sym_valid_o !== 1'b1 || sym_o !== exp_after[i]) begin
                failures++;
                $display("FAIL bp_resume[%0d]: got valid=%b sym=%h want 1/%h",
                         i, sym_valid_o, sym_o, exp_after[i]);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midstream();
        do_reset();
        step(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sym_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_held: got valid=%b want 1", sym_valid_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sym_valid_o !== 1'b0 || sym_o !== 8'h00) begin
            failures++;
            $display("FAIL mid_async_drop: got valid=%b sym=%h want 0/00", sym_valid_o, sym_o);
        end
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (sym_valid_o !== 1'b1 || sym_o !== 8'hFF || sym_k_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_seed_d00: got valid=%b sym=%h want 1/ff", sym_valid_o, sym_o);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int         accepted = 0;
        int         cycles   = 0;
        logic       v, k, d, r;
        logic [7:0] s;
        logic [8:0] e;
        logic       hold_pending = 1'b0;
        logic [8:0] hold_val = 9'h000;
        int         cls;
        do_reset();
        exp_q.delete();
        while (accepted < 10000 && cycles < 40000) begin
            v = ($urandom_range(3) != 0);
            r = ($urandom_range(3) != 0);
            d = ($urandom_range(7) == 0);
            cls = $urandom_range(15);
            s = 8'($urandom);
            k = 1'b0;
            if (cls == 0) begin
                k = 1'b1; s = 8'hBC;
            end else if (cls == 1) begin
                k = 1'b1; s = 8'h1C;
            end else if (cls == 2) begin
                k = 1'b1;
                if (s == 8'hBC || s == 8'h1C) s = 8'hF7;
            end
            step(v, s, k, d, r);
            cycles++;
            if (hold_pending) begin
                checks++;
                if ({pre_k, pre_sym} !== hold_val) begin
                    failures++;
                    $display("FAIL rnd_stable: got %h want %h at cycle %0d",
                             {pre_k, pre_sym}, hold_val, cycles);
                end
            end
            if (pre_fire) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra: got %h want none at cycle %0d",
                             {pre_k, pre_sym}, cycles);
                end else begin
                    e = exp_q.pop_front();
                    if ({pre_k, pre_sym} !== e) begin
                        failures++;
                        $display("FAIL rnd_data: got %h want %h at cycle %0d",
                                 {pre_k, pre_sym}, e, cycles);
                    end
                end
            end
            hold_pending = 1'b0;
            if (sym_valid_o && !r && !pre_acc) begin
                hold_pending = 1'b1;
                hold_val = {pre_k, pre_sym};
            end
            if (pre_acc) begin
                model_sym(s, k, d, e);
                exp_q.push_back(e);
                accepted++;
            end
        end
        checks++;
        if (accepted < 10000) begin
            failures++;
            $display("FAIL rnd_budget: got %0d accepted want 10000", accepted);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            if (pre_fire) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_drain_extra: got %h want none", {pre_k, pre_sym});
                end else begin
                    e = exp_q.pop_front();
                    if ({pre_k, pre_sym} !== e) begin
                        failures++;
                        $display("FAIL rnd_drain: got %h want %h", {pre_k, pre_sym}, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || sym_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rnd_lost: got %0d pending valid=%b want 0/0", exp_q.size(), sym_valid_o);
        end
    endtask

    initial begin
        logic [8:0] in_a[5]   = '{9'h1BC, 9'h000, 9'h000, 9'h000, 9'h000};
        logic       dis_a[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [8:0] exp_a[5]  = '{9'h1BC, 9'h0FF, 9'h017, 9'h0C0, 9'h014};
        logic [8:0] in_b[5]   = '{9'h1BC, 9'h000, 9'h11C, 9'h000, 9'h000};
        logic [8:0] exp_b[5]  = '{9'h1BC, 9'h0FF, 9'h11C, 9'h017, 9'h0C0};
        logic [8:0] in_c[5]   = '{9'h1BC, 9'h0A5, 9'h0A5, 9'h000, 9'h000};
        logic       dis_c[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [8:0] exp_c[5]  = '{9'h1BC, 9'h0A5, 9'h0A5, 9'h0C0, 9'h014};
        build_keystream();
        sym_valid_i = 1'b0; sym_i = 8'h00; sym_k_i = 1'b0;
        scramble_dis_i = 1'b0; sym_ready_i = 1'b1;
        test_reset();
        test_sequence("com_d00", in_a, dis_a, exp_a);
        test_sequence("skp", in_b, dis_a, exp_b);
        test_sequence("bypass", in_c, dis_c, exp_c);
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcie_scrambler_8b.md
PCIE_SCRAMBLER_8B -- requirements
Module: pcie_scrambler_8b

Interface
REQ-001 The block SHALL have one parameter: LFSR_SEED, default 16'hFFFF, the LFSR load value on reset and on COM.
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk_i, input, 1, sole clock, rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- sym_i, input, 8, unscrambled symbol byte.
- sym_k_i, input, 1, sym_i is a K (control) symbol.
- sym_valid_i, input, 1, input symbol valid.
- sym_ready_o, output, 1, block accepts the input symbol this cycle.
- scramble_dis_i, input, 1, pass D symbols unscrambled (training sets, loopback).
- sym_o, output, 8, symbol byte to the encoder data_i.
- sym_k_o, output, 1, K flag to the encoder is_special_k_i.
- sym_valid_o, output, 1, output symbol valid.
- sym_ready_i, input, 1, downstream accepts the output symbol.

Function
REQ-003 A transfer SHALL occur on an input when valid and ready are both high at a rising clk_i edge.
REQ-004 sym_ready_o SHALL equal (!sym_valid_o || sym_ready_i), so throughput is one symbol per cycle with no combinational valid-to-ready path.
REQ-005 An accepted symbol SHALL appear on sym_o/sym_k_o with sym_valid_o high exactly 1 cycle later (registered output stage).
REQ-006 While sym_valid_o is high and sym_ready_i is low, sym_o, sym_k_o and sym_valid_o SHALL hold stable.
REQ-007 The LFSR SHALL be 16 bits, implement G(X)=X^16+X^5+X^4+X^3+1 in Galois form, and advance 8 shifts per accepted symbol.
REQ-008 The scramble mask for a D symbol SHALL be the 8 successive LFSR[15] outputs applied to bits 0..7, with bit 0 first.
REQ-009 An accepted COM (K28.5, 8'hBC, sym_k_i=1) SHALL load the LFSR with LFSR_SEED, SHALL NOT advance it, and SHALL pass through unscrambled.
REQ-010 An accepted SKP (K28.0, 8'h1C, sym_k_i=1) SHALL pass through unscrambled and SHALL leave the LFSR unchanged.
REQ-011 Any other accepted K symbol SHALL pass through unscrambled and SHALL advance the LFSR by 8.
REQ-012 An accepted D symbol SHALL be XORed with the mask and SHALL advance the LFSR by 8.
REQ-013 When scramble_dis_i is high, the mask SHALL be zero, and the LFSR SHALL still advance and load per REQ-009 to REQ-012.
REQ-014 A cycle with no transfer SHALL leave the LFSR unchanged.
REQ-015 scramble_dis_i SHALL be sampled in the same cycle as the accepted symbol.
REQ-016 sym_k_o SHALL equal the accepted sym_k_i.

Reset
REQ-017 While rst_i is asserted: LFSR=LFSR_SEED, sym_o=8'h00, sym_k_o=0, sym_valid_o=0, and sym_ready_o=1 once released.
REQ-018 Reset asserted mid-stream SHALL discard the held output symbol immediately (asynchronous) without emitting a partial transfer.
REQ-019 The first D symbol after reset release SHALL use the LFSR_SEED state.

Structure
REQ-020 A shared package pcie_phy_pkg SHALL hold: K_COM=8'hBC, K_SKP=8'h1C, SCRAMBLE_POLY=16'h0039, and a function lfsr_adv8 returning the next state and the 8-bit mask.
REQ-021 The block SHALL be a single module with no sub-modules.
REQ-022 The LFSR and mask logic SHALL be purely combinational from the current state (one 8-step unrolled function).
REQ-023 The block SHALL sit directly upstream of encoder_8b10b in pcie_phys_top.

Verification
REQ-024 COM then four D 8'h00 with sym_ready_i=1 and scramble_dis_i=0 -> outputs BC(K), FF, 17, C0, 14, each 1 cycle after acceptance.
REQ-025 COM, D00, SKP, D00, D00 -> outputs BC, FF, 1C(K), 17, C0 (SKP does not advance the LFSR).
REQ-026 Backpressure: sym_ready_i low for 3 cycles while streaming D00 after COM -> output held stable, sym_ready_o low, no symbol lost or duplicated, mask sequence continues FF, 17, C0.
REQ-027 scramble_dis_i=1 for 2 D symbols A5, A5 after COM, then 0 for D00 -> A5, A5, C0 (LFSR advanced through bypassed symbols).
REQ-028 Assert rst_i while sym_valid_o=1 and sym_ready_i=0 -> sym_valid_o drops immediately; after release, D00 without COM -> FF.
REQ-029 Random valid/ready stress over 10k symbols against a reference model -> bit-exact output stream, with every accepted symbol emitted exactly once and in order.
